// File: rtl/seg7_pkg.sv
// Shared codes and segment patterns for the 7-segment scan reader.
// Pattern bit order is {a,b,c,d,e,f,g}, with bit 6 = a.
package seg7_pkg;

  typedef logic [3:0] code_t;

  localparam code_t CODE_BLANK = 4'hF;
  localparam code_t CODE_ERR   = 4'hE;

  localparam logic [6:0] PAT_0     = 7'h7E;
  localparam logic [6:0] PAT_1     = 7'h30;
  localparam logic [6:0] PAT_2     = 7'h6D;
  localparam logic [6:0] PAT_3     = 7'h79;
  localparam logic [6:0] PAT_4     = 7'h33;
  localparam logic [6:0] PAT_5     = 7'h5B;
  localparam logic [6:0] PAT_6     = 7'h1F;
  localparam logic [6:0] PAT_7     = 7'h70;
  localparam logic [6:0] PAT_8     = 7'h7F;
  localparam logic [6:0] PAT_9     = 7'h73;
  localparam logic [6:0] PAT_BLANK = 7'h00;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup from a 7-segment pattern to a digit code.
// Any pattern outside the map decodes to CODE_ERR.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat_i,
  output code_t      code_o
);

  always_comb begin
    code_o = CODE_ERR;
    case (pat_i)
      PAT_0:     code_o = 4'h0;
      PAT_1:     code_o = 4'h1;
      PAT_2:     code_o = 4'h2;
      PAT_3:     code_o = 4'h3;
      PAT_4:     code_o = 4'h4;
      PAT_5:     code_o = 4'h5;
      PAT_6:     code_o = 4'h6;
      PAT_7:     code_o = 4'h7;
      PAT_8:     code_o = 4'h8;
      PAT_9:     code_o = 4'h9;
      PAT_BLANK: code_o = CODE_BLANK;
      default:   code_o = CODE_ERR;
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Receive side of a multiplexed 7-segment link: sync, capture, per-digit filter, framed output.
// Define SEG7_ACTIVE_LOW_EN for common-anode panels (seg_in and dig_sel active low).
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int unsigned NDIG         = 4,
  parameter int unsigned SAMPLE_DLY   = 2,
  parameter int unsigned STABLE_SCANS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          seg_in,
  input  logic [NDIG-1:0]     dig_sel,
  output logic [4*NDIG-1:0]   frame_data,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic [7:0]          err_cnt
);

  localparam logic [4:0] CapAt  = 5'(SAMPLE_DLY + 1);
  localparam logic [4:0] RunMax = 5'(SAMPLE_DLY + 2);
  localparam logic [2:0] CntMax = 3'(STABLE_SCANS);

  logic [6:0]      seg_s1_q, seg_s2_q, seg_syn;
  logic [NDIG-1:0] sel_s1_q, sel_s2_q, sel_syn, sel_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= '0;
      seg_s2_q <= '0;
      sel_s1_q <= '0;
      sel_s2_q <= '0;
    end else begin
      seg_s1_q <= seg_in;
      seg_s2_q <= seg_s1_q;
      sel_s1_q <= dig_sel;
      sel_s2_q <= sel_s1_q;
    end
  end

`ifdef SEG7_ACTIVE_LOW_EN
  assign seg_syn = ~seg_s2_q;
  assign sel_syn = ~sel_s2_q;
`else
  assign seg_syn = seg_s2_q;
  assign sel_syn = sel_s2_q;
`endif

  code_t dec_code;

  seg7_pattern_decode u_decode (
    .pat_i  (seg_syn),
    .code_o (dec_code)
  );

  logic                  sel_onehot, cap;
  logic [4:0]            run_q, run_d, held;
  logic [NDIG-1:0][3:0]  cand_q, cand_d, comm_q, comm_d, frame_q, frame_d;
  logic [NDIG-1:0][2:0]  cnt_q, cnt_d;
  logic                  dirty_q, dirty_d, valid_q, valid_d, commit_any;
  logic [7:0]            err_q, err_d;

  assign sel_onehot = (sel_syn != '0) && ((sel_syn & (sel_syn - NDIG'(1))) == '0);

  // held = cycles the current one-hot select has been seen, including this one
  always_comb begin
    held  = (sel_syn != sel_prev_q) ? 5'd1 : run_q + 5'd1;
    cap   = sel_onehot && (held == CapAt);
    run_d = !sel_onehot ? 5'd0 : (held > RunMax) ? RunMax : held;
  end

  always_comb begin
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    comm_d     = comm_q;
    frame_d    = frame_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    err_d      = err_q;
    commit_any = 1'b0;

    for (int i = 0; i < NDIG; i++) begin
      if (cap && sel_syn[i]) begin
        if (dec_code == cand_q[i]) begin
          if (cnt_q[i] != CntMax) cnt_d[i] = cnt_q[i] + 3'd1;
        end else begin
          cand_d[i] = dec_code;
          cnt_d[i]  = 3'd1;
        end
      end
      if (cnt_q[i] == CntMax && cand_q[i] != comm_q[i]) begin
        comm_d[i]  = cand_q[i];
        commit_any = 1'b1;
      end
    end

    if (cap && dec_code == CODE_ERR && err_q != 8'hFF) err_d = err_q + 8'd1;

    if (dirty_q && (!valid_q || frame_ready)) begin
      frame_d = comm_q;
      valid_d = 1'b1;
      dirty_d = 1'b0;
    end else if (valid_q && frame_ready) begin
      valid_d = 1'b0;
    end
    // A commit landing with a frame load must survive into the next frame
    if (commit_any) dirty_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_prev_q <= '0;
      run_q      <= '0;
      cand_q     <= {NDIG{CODE_BLANK}};
      cnt_q      <= '0;
      comm_q     <= {NDIG{CODE_BLANK}};
      frame_q    <= {NDIG{CODE_BLANK}};
      valid_q    <= 1'b0;
      dirty_q    <= 1'b0;
      err_q      <= '0;
    end else begin
      sel_prev_q <= sel_syn;
      run_q      <= run_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      comm_q     <= comm_d;
      frame_q    <= frame_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      err_q      <= err_d;
    end
  end

  assign frame_data  = frame_q;
  assign frame_valid = valid_q;
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader (NDIG=4, SAMPLE_DLY=2, STABLE_SCANS=2, 8-cycle dwell).
// Stimulus polarity follows SEG7_ACTIVE_LOW_EN so the same expectations hold in both builds.
module tb_seg7_scan_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  dig_sel;
  logic [15:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic [7:0]  err_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int frames      = 0;
  int f0;

  always #5 clk = ~clk;

  seg7_scan_reader #(
    .NDIG         (4),
    .SAMPLE_DLY   (2),
    .STABLE_SCANS (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .err_cnt     (err_cnt)
  );

  // Handshake seen half a cycle before the edge that completes it
  always @(negedge clk) if (rst_n && frame_valid && frame_ready) frames++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] s, input logic [3:0] d);
`ifdef SEG7_ACTIVE_LOW_EN
    seg_in  = ~s;
    dig_sel = ~d;
`else
    seg_in  = s;
    dig_sel = d;
`endif
  endtask

  task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                      input logic [6:0] p2, input logic [6:0] p3);
    drive(p0, 4'b0001); cycles(8);
    drive(p1, 4'b0010); cycles(8);
    drive(p2, 4'b0100); cycles(8);
    drive(p3, 4'b1000); cycles(8);
  endtask

  task automatic idle(input int n);
    drive(7'h00, 4'b0000);
    cycles(n);
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_ready = 1'b1;
    drive(7'h00, 4'b0000);
    #23;
    check("rst_data",  {16'h0, frame_data}, 32'h0000_FFFF);
    check("rst_valid", {31'h0, frame_valid}, 32'h0);
    check("rst_err",   {24'h0, err_cnt}, 32'h0);
    cycles(1);
    rst_n = 1'b1;

    // Blank scan matches the reset committed value: nothing to report
    scan(7'h00, 7'h00, 7'h00, 7'h00);
    idle(8);
    check("blank_valid",  {31'h0, frame_valid}, 32'h0);
    check("blank_frames", frames, 32'd0);

    scan(7'h30, 7'h6D, 7'h79, 7'h33);
    scan(7'h30, 7'h6D, 7'h79, 7'h33);
    idle(8);
    check("s2_data",   {16'h0, frame_data}, 32'h0000_4321);
    check("s2_valid",  {31'h0, frame_valid}, 32'h0);
    check("s2_frames", {31'h0, frames > 0}, 32'h1);

    // A single glitched scan never reaches the stable count
    f0 = frames;
    scan(7'h7F, 7'h6D, 7'h79, 7'h33);
    scan(7'h30, 7'h6D, 7'h79, 7'h33);
    scan(7'h30, 7'h6D, 7'h79, 7'h33);
    idle(8);
    check("s3_frames", frames, f0);
    check("s3_err",    {24'h0, err_cnt}, 32'h0);
    check("s3_data",   {16'h0, frame_data}, 32'h0000_4321);

    scan(7'h30, 7'h6D, 7'h01, 7'h33);
    scan(7'h30, 7'h6D, 7'h01, 7'h33);
    idle(8);
    check("s4_err",  {24'h0, err_cnt}, 32'h2);
    check("s4_data", {16'h0, frame_data}, 32'h0000_4E21);

    scan(7'h30, 7'h6D, 7'h79, 7'h33);
    scan(7'h30, 7'h6D, 7'h79, 7'h33);
    idle(8);
    check("s5_restore", {16'h0, frame_data}, 32'h0000_4321);

    frame_ready = 1'b0;
    scan(7'h5B, 7'h6D, 7'h79, 7'h33);
    scan(7'h5B, 7'h6D, 7'h79, 7'h33);
    idle(8);
    check("s5_first_data",  {16'h0, frame_data}, 32'h0000_4325);
    check("s5_first_valid", {31'h0, frame_valid}, 32'h1);
    scan(7'h5B, 7'h1F, 7'h79, 7'h33);
    scan(7'h5B, 7'h1F, 7'h79, 7'h33);
    idle(8);
    check("s5_hold_data",  {16'h0, frame_data}, 32'h0000_4325);
    check("s5_hold_valid", {31'h0, frame_valid}, 32'h1);
    frame_ready = 1'b1;
    cycles(1);
    check("s5_next_data",  {16'h0, frame_data}, 32'h0000_4365);
    check("s5_next_valid", {31'h0, frame_valid}, 32'h1);
    cycles(1);
    check("s5_drain_valid", {31'h0, frame_valid}, 32'h0);

    scan(7'h7E, 7'h70, 7'h7F, 7'h73);
    scan(7'h7E, 7'h70, 7'h7F, 7'h73);
    idle(8);
    check("s5b_data", {16'h0, frame_data}, 32'h0000_9870);

    // Two selects at once: an ERR pattern must not be captured
    drive(7'h01, 4'b0011);
    cycles(20);
    idle(6);
    check("s6_err",   {24'h0, err_cnt}, 32'h2);
    check("s6_valid", {31'h0, frame_valid}, 32'h0);

    drive(7'h30, 4'b0001);
    cycles(5);
    rst_n = 1'b0;
    #1;
    check("s6_rst_data",  {16'h0, frame_data}, 32'h0000_FFFF);
    check("s6_rst_valid", {31'h0, frame_valid}, 32'h0);
    check("s6_rst_err",   {24'h0, err_cnt}, 32'h0);
    cycles(3);
    rst_n = 1'b1;
    cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
